// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // Controller side drives operands and launch request
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  // Subtractor side returns status and registered result
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per clock,
// with one full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_d;

  // Full-subtractor cell on the current LSBs and next result/counter values
  always_comb begin
    d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    res_d = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    cnt_d = cnt_q + CW'(1);
  end

  // Control FSM and datapath registers; diff/bout update only on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            br_q    <= bus.bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          br_q  <= br_d;
          res_q <= res_d;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_d;
          if (cnt_d == CW'(WIDTH)) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Launch one WIDTH=8 operation and measure edges to done and busy cycles
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     output int lat, output int busy_cnt);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bi;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      if (bus8.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Launch one WIDTH=1 operation and measure edges to done and busy cycles
  task automatic op1(input logic a, input logic b, input logic bi,
                     output int lat, output int busy_cnt);
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.bin = bi;
    @(negedge clk);
    bus1.start = 1'b0; bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.bin = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (bus1.done !== 1'b1 && lat < 20) begin
      if (bus1.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    #2 rst = 1'b1;
    #2;
    tests_run++;
    if ({bus8.busy, bus8.done, bus8.bout, bus8.diff} !== 11'h0) begin
      tests_failed++;
      $display("FAIL reset8: busy=%b done=%b bout=%b diff=%h, expected all zero",
               bus8.busy, bus8.done, bus8.bout, bus8.diff);
    end
    tests_run++;
    if ({bus1.busy, bus1.done, bus1.bout, bus1.diff} !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset1: busy=%b done=%b bout=%b diff=%b, expected all zero",
               bus1.busy, bus1.done, bus1.bout, bus1.diff);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    op8(8'h5A, 8'h3C, 1'b0, lat, bc);
    tests_run++;
    if (lat !== 8 || bc !== 8) begin
      tests_failed++;
      $display("FAIL basic_timing: latency=%0d busy_cycles=%0d, expected 8 and 8", lat, bc);
    end
    tests_run++;
    if (bus8.diff !== 8'h1E || bus8.bout !== 1'b0 || bus8.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: diff=%h bout=%b busy=%b, expected 1e 0 0",
               bus8.diff, bus8.bout, bus8.busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus8.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: done=%b, expected 0 one cycle after", bus8.done);
    end
  endtask

  task automatic test_borrow();
    int lat, bc;
    op8(8'h00, 8'h01, 1'b0, lat, bc);
    tests_run++;
    if (bus8.diff !== 8'hFF || bus8.bout !== 1'b1 || lat !== 8) begin
      tests_failed++;
      $display("FAIL borrow_00_01: diff=%h bout=%b lat=%0d, expected ff 1 8",
               bus8.diff, bus8.bout, lat);
    end
    op8(8'h10, 8'h10, 1'b1, lat, bc);
    tests_run++;
    if (bus8.diff !== 8'hFF || bus8.bout !== 1'b1 || lat !== 8) begin
      tests_failed++;
      $display("FAIL borrow_10_10_bin: diff=%h bout=%b lat=%0d, expected ff 1 8",
               bus8.diff, bus8.bout, lat);
    end
  endtask

  task automatic test_hold();
    int lat, bc, extra_done, extra_busy;
    op8(8'h5A, 8'h3C, 1'b0, lat, bc);
    tests_run++;
    if (bus8.diff !== 8'h1E) begin
      tests_failed++;
      $display("FAIL hold_prior: diff=%h, expected 1e", bus8.diff);
    end
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00; bus8.bin = 1'b0;
    @(negedge clk);
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      tests_run++;
      if (bus8.diff !== 8'h1E) begin
        tests_failed++;
        $display("FAIL hold_diff_during_run: cycle %0d diff=%h, expected 1e", lat, bus8.diff);
      end
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    bus8.start = 1'b0;
    tests_run++;
    if (bus8.diff !== 8'hFF || bus8.bout !== 1'b0 || lat !== 8) begin
      tests_failed++;
      $display("FAIL hold_result: diff=%h bout=%b lat=%0d, expected ff 0 8",
               bus8.diff, bus8.bout, lat);
    end
    extra_done = 0; extra_busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus8.done === 1'b1) extra_done++;
      if (bus8.busy === 1'b1) extra_busy++;
    end
    tests_run++;
    if (extra_done !== 0 || extra_busy !== 0) begin
      tests_failed++;
      $display("FAIL hold_single_done: extra done=%0d extra busy=%0d, expected 0 0",
               extra_done, extra_busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    op8(8'h33, 8'h11, 1'b0, lat, bc);
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h7F; bus8.bin = 1'b0;
    tests_run++;
    if (bus8.done !== 1'b1 || bus8.diff !== 8'h22 || bus8.bout !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: done=%b diff=%h bout=%b, expected 1 22 0",
               bus8.done, bus8.diff, bus8.bout);
    end
    @(negedge clk);
    bus8.start = 1'b0;
    tests_run++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: done=%b busy=%b, expected 0 1", bus8.done, bus8.busy);
    end
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== 8 || bus8.diff !== 8'h01 || bus8.bout !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: lat=%0d diff=%h bout=%b, expected 8 01 0",
               lat, bus8.diff, bus8.bout);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, stray;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus8.busy !== 1'b0 || bus8.diff !== 8'h00 || bus8.bout !== 1'b0 || bus8.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_clear: busy=%b diff=%h bout=%b done=%b, expected 0 00 0 0",
               bus8.busy, bus8.diff, bus8.bout, bus8.done);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: stray done/busy cycles=%0d, expected 0", stray);
    end
    op8(8'h5A, 8'h3C, 1'b0, lat, bc);
    tests_run++;
    if (lat !== 8 || bc !== 8 || bus8.diff !== 8'h1E || bus8.bout !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_rerun: lat=%0d busy=%0d diff=%h bout=%b, expected 8 8 1e 0",
               lat, bc, bus8.diff, bus8.bout);
    end
  endtask

  task automatic test_random_w8();
    int lat, bc;
    logic [7:0] a, b;
    logic bi;
    logic [8:0] exp;
    for (int n = 0; n < 600; n++) begin
      a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
      exp = {1'b0, a} - {1'b0, b} - 9'(bi);
      op8(a, b, bi, lat, bc);
      tests_run++;
      if ({bus8.bout, bus8.diff} !== exp || lat !== 8 || bc !== 8 || bus8.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand8 %h-%h-%b: got %h lat=%0d busy=%0d, expected %h lat=8 busy=8",
                 a, b, bi, {bus8.bout, bus8.diff}, lat, bc, exp);
      end
    end
  endtask

  task automatic test_random_w1();
    int lat, bc;
    logic a, b, bi;
    logic [1:0] exp;
    for (int n = 0; n < 500; n++) begin
      a = 1'($urandom); b = 1'($urandom); bi = 1'($urandom);
      exp = {1'b0, a} - {1'b0, b} - 2'(bi);
      op1(a, b, bi, lat, bc);
      tests_run++;
      if ({bus1.bout, bus1.diff} !== exp || lat !== 1 || bc !== 1 || bus1.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand1 %b-%b-%b: got %b lat=%0d busy=%0d, expected %b lat=1 busy=1",
                 a, b, bi, {bus1.bout, bus1.diff}, lat, bc, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random_w8();
    test_random_w1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
